// File: rtl/rv32_fetch_stage_pkg.sv
// Shared definitions for the RV32 fetch stage: exception codes, opcodes, NOP and FSM states.
package rv32_fetch_stage_pkg;

  localparam logic [3:0] MCAUSE_INSTR_MISALIGNED    = 4'd0;
  localparam logic [3:0] MCAUSE_INSTR_ACCESS_FAULT  = 4'd1;
  localparam logic [3:0] MCAUSE_ILLEGAL_INSTRUCTION = 4'd2;
  localparam logic [3:0] MCAUSE_BREAKPOINT          = 4'd3;
  localparam logic [3:0] MCAUSE_ECALL_M             = 4'd11;

  localparam logic [6:0] RV32_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_OPCODE_BRANCH = 7'b1100011;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN,
    TRAP_WAIT
  } fetch_state_t;

endpackage

// File: rtl/rv32_fetch_stage_branch_predictor.sv
// Static predictor: JAL always taken, backward conditional branches taken, misaligned targets suppressed.
module rv32_branch_predictor
  import rv32_fetch_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        taken,
  output logic [31:0] target
);

  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign opcode = instr[6:0];
  assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    taken  = 1'b0;
    target = pc + 32'd4;
    if (opcode == RV32_OPCODE_JAL) begin
      target = pc + j_imm;
      taken  = (target[1:0] == 2'b00);
    end else if (opcode == RV32_OPCODE_BRANCH && instr[31]) begin
      target = pc + b_imm;
      taken  = (target[1:0] == 2'b00);
    end
    if (!taken) target = pc + 32'd4;
  end

endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction-fetch stage with single-outstanding bus read and redirect handling.
// Define RV32_BRANCH_PREDICTOR_EN to enable static JAL/backward-branch prediction.
module rv32_fetch_stage
  import rv32_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] instr_address_out,
  output logic        instr_read_out,
  input  logic        instr_ready_in,
  input  logic [31:0] instr_read_value_in,
  input  logic        instr_fault_in,
  output logic        fetch_stall_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  exception_cause_out,
  output logic        branch_predicted_taken_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pending_pc;
  logic [31:0]  hold_instr;
  logic         hold_fault;
  logic         aligned;
  logic [31:0]  next_pc;
  logic         pred_taken;
  logic [31:0]  pred_target;

  assign aligned           = (pc[1:0] == 2'b00);
  assign instr_address_out = pc;
  assign instr_read_out    = ((state == FETCH) || (state == DRAIN)) && aligned;
  assign fetch_stall_out   = instr_read_out && !instr_ready_in;

`ifdef RV32_BRANCH_PREDICTOR_EN
  logic [31:0] pred_instr;

  // pc is frozen during HOLD, so the buffered word predicts against the same pc it was fetched from
  assign pred_instr = (state == HOLD) ? hold_instr : instr_read_value_in;

  rv32_branch_predictor u_predictor (
    .instr  (pred_instr),
    .pc     (pc),
    .taken  (pred_taken),
    .target (pred_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc + 32'd4;
`endif

  assign next_pc = pred_taken ? pred_target : (pc + 32'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= FETCH;
      pc                         <= RESET_VECTOR;
      pending_pc                 <= '0;
      hold_instr                 <= RV32_NOP;
      hold_fault                 <= 1'b0;
      valid_out                  <= 1'b0;
      exception_out              <= 1'b0;
      exception_cause_out        <= '0;
      branch_predicted_taken_out <= 1'b0;
      pc_out                     <= '0;
      instr_out                  <= RV32_NOP;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_in) begin
            // an unfinished read must be drained before the new target can be issued
            if (instr_read_out && !instr_ready_in) begin
              pending_pc <= redirect_pc_in;
              state      <= DRAIN;
            end else begin
              pc <= redirect_pc_in;
            end
            if (!stall_in) begin
              valid_out                  <= 1'b0;
              exception_out              <= 1'b0;
              branch_predicted_taken_out <= 1'b0;
            end
          end else if (!aligned) begin
            if (!stall_in) begin
              valid_out                  <= 1'b1;
              exception_out              <= 1'b1;
              exception_cause_out        <= MCAUSE_INSTR_MISALIGNED;
              branch_predicted_taken_out <= 1'b0;
              pc_out                     <= pc;
              instr_out                  <= RV32_NOP;
              state                      <= TRAP_WAIT;
            end
          end else if (instr_ready_in) begin
            if (stall_in) begin
              hold_instr <= instr_read_value_in;
              hold_fault <= instr_fault_in;
              state      <= HOLD;
            end else if (instr_fault_in) begin
              valid_out                  <= 1'b1;
              exception_out              <= 1'b1;
              exception_cause_out        <= MCAUSE_INSTR_ACCESS_FAULT;
              branch_predicted_taken_out <= 1'b0;
              pc_out                     <= pc;
              instr_out                  <= RV32_NOP;
              state                      <= TRAP_WAIT;
            end else begin
              valid_out                  <= 1'b1;
              exception_out              <= 1'b0;
              branch_predicted_taken_out <= pred_taken;
              pc_out                     <= pc;
              instr_out                  <= instr_read_value_in;
              pc                         <= next_pc;
            end
          end else if (!stall_in) begin
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            branch_predicted_taken_out <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_in) begin
            pc    <= redirect_pc_in;
            state <= FETCH;
            if (!stall_in) begin
              valid_out                  <= 1'b0;
              exception_out              <= 1'b0;
              branch_predicted_taken_out <= 1'b0;
            end
          end else if (!stall_in) begin
            valid_out <= 1'b1;
            pc_out    <= pc;
            if (hold_fault) begin
              exception_out              <= 1'b1;
              exception_cause_out        <= MCAUSE_INSTR_ACCESS_FAULT;
              branch_predicted_taken_out <= 1'b0;
              instr_out                  <= RV32_NOP;
              state                      <= TRAP_WAIT;
            end else begin
              exception_out              <= 1'b0;
              branch_predicted_taken_out <= pred_taken;
              instr_out                  <= hold_instr;
              pc                         <= next_pc;
              state                      <= FETCH;
            end
          end
        end

        DRAIN: begin
          if (instr_ready_in) begin
            pc    <= redirect_in ? redirect_pc_in : pending_pc;
            state <= FETCH;
          end else if (redirect_in) begin
            pending_pc <= redirect_pc_in;
          end
          if (!stall_in) begin
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            branch_predicted_taken_out <= 1'b0;
          end
        end

        TRAP_WAIT: begin
          if (redirect_in) begin
            pc    <= redirect_pc_in;
            state <= FETCH;
          end
          if (!stall_in) begin
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            branch_predicted_taken_out <= 1'b0;
          end
        end

        default: state <= FETCH;
      endcase

      if (flush_in && !stall_in) begin
        valid_out                  <= 1'b0;
        exception_out              <= 1'b0;
        branch_predicted_taken_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Table-driven bench for rv32_fetch_stage plus hand sequences for drain overwrite and mid-read reset.
module tb_rv32_fetch_stage;

`ifdef RV32_BRANCH_PREDICTOR_EN
  localparam logic        PRED    = 1'b1;
  localparam logic [31:0] BR_NEXT = 32'h0000_010C;
`else
  localparam logic        PRED    = 1'b0;
  localparam logic [31:0] BR_NEXT = 32'h0000_0114;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic        instr_ready_in = 1'b0;
  logic [31:0] instr_read_value_in = '0;
  logic        instr_fault_in = 1'b0;
  logic        fetch_stall_out;
  logic        valid_out;
  logic        exception_out;
  logic [3:0]  exception_cause_out;
  logic        branch_predicted_taken_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rv32_fetch_stage #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .redirect_in                (redirect_in),
    .redirect_pc_in             (redirect_pc_in),
    .instr_address_out          (instr_address_out),
    .instr_read_out             (instr_read_out),
    .instr_ready_in             (instr_ready_in),
    .instr_read_value_in        (instr_read_value_in),
    .instr_fault_in             (instr_fault_in),
    .fetch_stall_out            (fetch_stall_out),
    .valid_out                  (valid_out),
    .exception_out              (exception_out),
    .exception_cause_out        (exception_cause_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out)
  );

  typedef struct {
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        ready, fault;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_read, e_fstall;
    logic        e_valid, e_exc;
    logic [3:0]  e_cause;
    logic        e_pred;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] rp,
                              input logic rdy, input logic flt, input logic [31:0] dat,
                              input logic [31:0] ea, input logic er, input logic efs,
                              input logic ev, input logic ee, input logic [3:0] ec, input logic ep,
                              input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.stall = st; v.flush = fl; v.redir = rd; v.rpc = rp;
    v.ready = rdy; v.fault = flt; v.rdata = dat;
    v.e_addr = ea; v.e_read = er; v.e_fstall = efs;
    v.e_valid = ev; v.e_exc = ee; v.e_cause = ec; v.e_pred = ep;
    v.e_pc = epc; v.e_instr = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            st fl rd rpc           rdy flt rdata          addr          rd fs  v  e  c  p     pc_out        instr
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0100_0013, 32'h100, 1, 0,  1, 0, 0, 0,    32'h100, 32'h0100_0013));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h104, 1, 1,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h104, 1, 1,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h104, 1, 1,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0104_0013, 32'h104, 1, 0,  1, 0, 0, 0,    32'h104, 32'h0104_0013));
    vecs.push_back(mk(1, 0, 0, 32'h0,       1, 0, 32'hDEAD_BEEF, 32'h108, 1, 0,  1, 0, 0, 0,    32'h104, 32'h0104_0013));
    vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 32'h0,         32'h108, 0, 0,  1, 0, 0, 0,    32'h104, 32'h0104_0013));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h108, 0, 0,  1, 0, 0, 0,    32'h108, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h10C, 1, 1,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h200,     0, 0, 32'h0,         32'h10C, 1, 1,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h10C, 1, 1,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h010C_0013, 32'h10C, 1, 0,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0200_0013, 32'h200, 1, 0,  1, 0, 0, 0,    32'h200, 32'h0200_0013));
    vecs.push_back(mk(0, 1, 0, 32'h0,       1, 0, 32'h0204_0013, 32'h204, 1, 0,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0208_0013, 32'h208, 1, 0,  1, 0, 0, 0,    32'h208, 32'h0208_0013));
    vecs.push_back(mk(0, 0, 1, 32'h202,     1, 0, 32'h020C_0013, 32'h20C, 1, 0,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,         32'h202, 0, 0,  1, 1, 0, 0,    32'h202, 32'h0000_0013));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,         32'h202, 0, 0,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h300,     0, 0, 32'h0,         32'h202, 0, 0,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0300_0013, 32'h300, 1, 0,  1, 0, 0, 0,    32'h300, 32'h0300_0013));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h0,         32'h304, 1, 0,  1, 1, 1, 0,    32'h304, 32'h0000_0013));
    vecs.push_back(mk(0, 0, 1, 32'h110,     1, 0, 32'h0,         32'h304, 0, 0,  0, 0, 0, 0,    32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'hFE00_0EE3, 32'h110, 1, 0,  1, 0, 0, PRED, 32'h110, 32'hFE00_0EE3));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0AAA_0013, BR_NEXT, 1, 0,  1, 0, 0, 0,    BR_NEXT, 32'h0AAA_0013));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", {31'd0, valid_out}, 32'd0);
    check("reset exc", {31'd0, exception_out}, 32'd0);
    check("reset cause", {28'd0, exception_cause_out}, 32'd0);
    check("reset pred", {31'd0, branch_predicted_taken_out}, 32'd0);
    check("reset pc_out", pc_out, 32'h0);
    check("reset instr", instr_out, 32'h0000_0013);
    check("reset addr", instr_address_out, 32'h100);
    check("reset read", {31'd0, instr_read_out}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall_in            = vecs[i].stall;
      flush_in            = vecs[i].flush;
      redirect_in         = vecs[i].redir;
      redirect_pc_in      = vecs[i].rpc;
      instr_ready_in      = vecs[i].ready;
      instr_fault_in      = vecs[i].fault;
      instr_read_value_in = vecs[i].rdata;
      #1;
      check($sformatf("v%0d addr", i), instr_address_out, vecs[i].e_addr);
      check($sformatf("v%0d read", i), {31'd0, instr_read_out}, {31'd0, vecs[i].e_read});
      check($sformatf("v%0d fstall", i), {31'd0, fetch_stall_out}, {31'd0, vecs[i].e_fstall});
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), {31'd0, valid_out}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d exc", i), {31'd0, exception_out}, {31'd0, vecs[i].e_exc});
      check($sformatf("v%0d pred", i), {31'd0, branch_predicted_taken_out}, {31'd0, vecs[i].e_pred});
      if (vecs[i].e_exc)
        check($sformatf("v%0d cause", i), {28'd0, exception_cause_out}, {28'd0, vecs[i].e_cause});
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
        check($sformatf("v%0d instr", i), instr_out, vecs[i].e_instr);
      end
      @(negedge clk);
    end

    // second redirect during drain replaces the first
    stall_in = 1'b0; flush_in = 1'b0; instr_fault_in = 1'b0;
    instr_ready_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h400;
    #1;
    check("drain pending read", {31'd0, fetch_stall_out}, 32'd1);
    @(negedge clk);
    redirect_pc_in = 32'h500;
    @(negedge clk);
    redirect_in = 1'b0; instr_ready_in = 1'b1; instr_read_value_in = 32'h0BAD_0013;
    #1;
    check("drain addr held", instr_address_out, BR_NEXT + 32'd4);
    @(posedge clk);
    #1;
    check("drain discard valid", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    instr_read_value_in = 32'h0500_0013;
    #1;
    check("drain new addr", instr_address_out, 32'h500);
    @(posedge clk);
    #1;
    check("drain first valid", {31'd0, valid_out}, 32'd1);
    check("drain first pc", pc_out, 32'h500);
    check("drain first instr", instr_out, 32'h0500_0013);

    // asynchronous reset abandons an in-flight read
    @(negedge clk);
    instr_ready_in = 1'b0;
    #1;
    check("midread addr", instr_address_out, 32'h504);
    reset_n = 1'b0;
    #1;
    check("midread reset addr", instr_address_out, 32'h100);
    check("midread reset valid", {31'd0, valid_out}, 32'd0);
    check("midread reset instr", instr_out, 32'h0000_0013);
    check("midread reset pc_out", pc_out, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; instr_ready_in = 1'b1; instr_read_value_in = 32'h0100_0013;
    @(posedge clk);
    #1;
    check("post reset valid", {31'd0, valid_out}, 32'd1);
    check("post reset pc", pc_out, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
